byte_encode_stream: RTL and testbench
=====================================

// Module: byte_encode_stream
// PURPOSE
//  Streaming ByteEncode_d packer: serialises N_COEFFS coefficients of d bits (1..D_MAX) into a byte stream.
//  Bits are packed little-endian (coefficient bit 0 first), and the byte stream is little-endian too.
//  Sits upstream of bits2bytes and replaces its whole-polynomial combinational bit vector with a
//  valid/ready byte stream, so downstream hash/serialiser stages consume one byte per cycle.
// PARAMETERS
//  N_COEFFS  256  coefficients per polynomial; N_COEFFS*d must be a multiple of 8
//  D_MAX     12   maximum bit width per coefficient
//  ACC_W     20   accumulator width; must be >= 7+D_MAX
// PORTS
//  clk_i          in   1      single clock, rising edge
//  rst_i          in   1      synchronous, active-high reset
//  start_i        in   1      begin a polynomial; d_i sampled on this cycle
//  d_i            in   4      bits per coefficient, legal 1..D_MAX
//  coeff_i        in   D_MAX  coefficient; only bits [d-1:0] are packed, upper bits ignored
//  coeff_valid_i  in   1      coeff_i valid
//  coeff_ready_o  out  1      block accepts coeff_i
//  byte_o         out  8      packed byte
//  byte_valid_o   out  1      byte_o valid
//  byte_ready_i   in   1      downstream accepts byte_o
//  byte_last_o    out  1      byte_o is the final byte (index 32*d-1 for N_COEFFS=256)
//  busy_o         out  1      state != IDLE
//  done_o         out  1      one-cycle pulse after the last byte handshake
//  err_o          out  1      one-cycle pulse: start_i with illegal d_i
// BEHAVIOUR
//  - Reset: state=IDLE, acc=0, acc_cnt=0, coeff_cnt=0, byte_cnt=0.
//    All outputs 0 (byte_o=8'h00, coeff_ready_o=0, byte_valid_o=0, done_o=0, err_o=0).
//  - Reset mid-operation aborts immediately. Partial bytes are discarded; the next start_i begins clean.
//  - States:
//      IDLE --start_i & legal d--> PACK
//      PACK --coeff_cnt==N_COEFFS (last coeff accepted)--> DRAIN
//      DRAIN --last byte handshake--> IDLE, with done_o=1 on the following cycle
//  - start_i with d_i==0 or d_i>D_MAX in IDLE: err_o=1 next cycle, state stays IDLE.
//    start_i outside IDLE is ignored; no error is raised.
//  - Coefficient handshake:
//      coeff_ready_o = (state==PACK) && (acc_cnt<8) && (coeff_cnt<N_COEFFS)
//      On coeff_valid_i && coeff_ready_o:
//        acc |= (coeff_i & mask_d) << acc_cnt; acc_cnt += d; coeff_cnt++
//  - Byte handshake:
//      byte_valid_o = (state!=IDLE) && (acc_cnt>=8); byte_o = acc[7:0]; combinational from registers.
//      On byte_valid_o && byte_ready_i: acc >>= 8; acc_cnt -= 8; byte_cnt++
//  - The two handshakes are mutually exclusive by construction: ready needs acc_cnt<8, valid needs
//    acc_cnt>=8. acc_cnt never exceeds 7+D_MAX, so ACC_W never overflows.
//  - byte_o and byte_last_o stay stable while byte_valid_o && !byte_ready_i; no bubble is inserted
//    on stall. byte_last_o = byte_valid_o && (byte_cnt == N_COEFFS*d/8 - 1).
//  - Because N_COEFFS*d is a multiple of 8, acc_cnt==0 at the last byte. No padding, no flush byte.
//  - Latency: first byte_valid_o is 1 cycle after the ceil(8/d)-th accepted coefficient.
//    Sustained rate is one handshake per cycle.
//  - d is latched at start and held constant for the whole polynomial; d_i changes mid-run are ignored.
// STRUCTURE
//  - Shared package conv_pkg: D_MAX, N_COEFFS, typedef enum {IDLE,PACK,DRAIN} enc_state_e,
//    and function bytes_per_poly(d) = N_COEFFS*d/8.
//  - One sub-module, bit_accum (ACC_W shift accumulator plus acc_cnt, push/pop ports).
//    It is reused by the decode direction.
//  - FSM and counters stay in byte_encode_stream.
// TESTING
//  1. d=1, 256 coeffs of 1, byte_ready_i=1 -> 32 bytes 8'hFF; byte_last_o on byte 31;
//     done_o one cycle later.
//  2. d=4, coeff[i]=i&15 -> bytes 8'h10,8'h32,8'h54,...,8'hFE repeating; 128 bytes total.
//  3. d=12, coeff0=12'h123, coeff1=12'hABC, rest 0 -> bytes 8'h23,8'hC1,8'hAB, then 8'h00 to 384 bytes.
//  4. d=12, byte_ready_i random 30% duty -> byte_o stable while stalled; stream equals golden bits2bytes
//     of the packed vector.
//  5. start_i with d_i=13 -> err_o pulse, busy_o=0, no coeff_ready_o.
//     Then d_i=0 -> same result.
//  6. d=10, rst_i asserted after 50 bytes -> all outputs 0 next cycle.
//     A fresh start with d=10 then yields a correct 320-byte stream.

Source files
------------

// File: rtl/byte_encode_stream_pkg.sv
// Shared definitions for the ByteEncode/ByteDecode streaming converters.
package byte_encode_stream_pkg;

    localparam int N_COEFFS = 256;
    localparam int D_MAX    = 12;
    localparam int ACC_W    = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } enc_state_e;

    function automatic int bytes_per_poly(input logic [3:0] d);
        return (N_COEFFS * int'(d)) / 8;
    endfunction

endpackage

// File: rtl/byte_encode_stream_bit_accum.sv
// Little-endian bit accumulator: variable-width pushes at the top of the valid
// bits, fixed 8-bit pops from the bottom.
module bit_accum #(
    parameter int ACC_W = 20,
    parameter int D_MAX = 12,
    parameter int CNT_W = $clog2(ACC_W + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [D_MAX-1:0] push_data_i,
    input  logic [3:0]       push_len_i,
    input  logic             pop_i,
    output logic [7:0]       pop_data_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] mask, field;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mask  = (ACC_W'(1) << push_len_i) - ACC_W'(1);
        field = (ACC_W'(push_data_i) & mask) << cnt_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        // Push and pop never coincide in the encoder; pop takes priority anyway.
        if (clr_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (pop_i) begin
            acc_d = acc_q >> 8;
            cnt_d = cnt_q - CNT_W'(8);
        end else if (push_i) begin
            acc_d = acc_q | field;
            cnt_d = cnt_q + CNT_W'(push_len_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign pop_data_o = acc_q[7:0];
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/byte_encode_stream.sv
// Streaming ByteEncode_d packer: N_COEFFS d-bit coefficients in, a little-endian
// byte stream out, valid/ready on both sides.
module byte_encode_stream #(
    parameter int N_COEFFS = 256,
    parameter int D_MAX    = 12,
    parameter int ACC_W    = 20
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       d_i,
    input  logic [D_MAX-1:0] coeff_i,
    input  logic             coeff_valid_i,
    output logic             coeff_ready_o,
    output logic [7:0]       byte_o,
    output logic             byte_valid_o,
    input  logic             byte_ready_i,
    output logic             byte_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    import byte_encode_stream_pkg::*;

    localparam int CNT_W  = $clog2(ACC_W + 1);
    localparam int CCNT_W = $clog2(N_COEFFS + 1);
    localparam int BCNT_W = $clog2(N_COEFFS * D_MAX / 8 + 1);

    enc_state_e        state_q;
    logic [3:0]        d_q;
    logic [CCNT_W-1:0] coeff_cnt_q;
    logic [BCNT_W-1:0] byte_cnt_q;
    logic [BCNT_W-1:0] last_idx;
    logic              done_q, err_q;
    logic [CNT_W-1:0]  acc_cnt;
    logic              d_legal, start_ok, coeff_fire, byte_fire;

    assign d_legal    = (d_i != 4'd0) && (int'(d_i) <= D_MAX);
    assign start_ok   = (state_q == IDLE) && start_i && d_legal;
    assign last_idx   = BCNT_W'((N_COEFFS * int'(d_q)) / 8 - 1);

    assign coeff_ready_o = (state_q == PACK) && (acc_cnt < CNT_W'(8))
                           && (coeff_cnt_q < CCNT_W'(N_COEFFS));
    assign byte_valid_o  = (state_q != IDLE) && (acc_cnt >= CNT_W'(8));
    assign byte_last_o   = byte_valid_o && (byte_cnt_q == last_idx);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign err_o         = err_q;

    assign coeff_fire = coeff_valid_i && coeff_ready_o;
    assign byte_fire  = byte_valid_o && byte_ready_i;

    bit_accum #(
        .ACC_W (ACC_W),
        .D_MAX (D_MAX),
        .CNT_W (CNT_W)
    ) u_accum (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (start_ok),
        .push_i      (coeff_fire),
        .push_data_i (coeff_i),
        .push_len_i  (d_q),
        .pop_i       (byte_fire),
        .pop_data_o  (byte_o),
        .cnt_o       (acc_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            d_q         <= 4'd0;
            coeff_cnt_q <= '0;
            byte_cnt_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (d_legal) begin
                            state_q     <= PACK;
                            d_q         <= d_i;
                            coeff_cnt_q <= '0;
                            byte_cnt_q  <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                PACK: begin
                    if (coeff_fire) begin
                        coeff_cnt_q <= coeff_cnt_q + CCNT_W'(1);
                        if (coeff_cnt_q == CCNT_W'(N_COEFFS - 1)) begin
                            state_q <= DRAIN;
                        end
                    end
                    if (byte_fire) begin
                        byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (byte_fire) begin
                        byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                        if (byte_last_o) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_byte_encode_stream.sv
// Directed bench for byte_encode_stream: table of polynomial runs checked against
// a bit-vector golden model, plus error-start and reset sequences.
module tb_byte_encode_stream;

    localparam int N  = 256;
    localparam int DM = 12;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [3:0]    d_i;
    logic [DM-1:0] coeff_i;
    logic          coeff_valid_i;
    logic          coeff_ready_o;
    logic [7:0]    byte_o;
    logic          byte_valid_o;
    logic          byte_ready_i;
    logic          byte_last_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          d;
        int          pat;        // 0 all ones, 1 i, 2 123/ABC then 0, 3 random, 4 i*37
        int          ready_pct;
        int          valid_pct;
        int          abort_at;   // reset after this many bytes, 0 = run to completion
        bit          chk_head;
        logic [23:0] head;       // expected first three bytes, byte 0 in [7:0]
    } vec_t;

    vec_t tbl [7];

    byte_encode_stream dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .d_i           (d_i),
        .coeff_i       (coeff_i),
        .coeff_valid_i (coeff_valid_i),
        .coeff_ready_o (coeff_ready_o),
        .byte_o        (byte_o),
        .byte_valid_o  (byte_valid_o),
        .byte_ready_i  (byte_ready_i),
        .byte_last_o   (byte_last_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_byte_o"}, byte_o, 0);
        check({tag, "_byte_valid"}, byte_valid_o, 0);
        check({tag, "_byte_last"}, byte_last_o, 0);
        check({tag, "_coeff_ready"}, coeff_ready_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
    endtask

    task automatic bad_start(input logic [3:0] d);
        @(negedge clk_i);
        start_i = 1'b1;
        d_i     = d;
        @(negedge clk_i);
        start_i = 1'b0;
        check($sformatf("err_pulse_d%0d", d), err_o, 1);
        check($sformatf("err_busy_d%0d", d), busy_o, 0);
        check($sformatf("err_coeff_ready_d%0d", d), coeff_ready_o, 0);
        @(negedge clk_i);
        check($sformatf("err_clears_d%0d", d), err_o, 0);
        check($sformatf("err_still_idle_d%0d", d), {busy_o, coeff_ready_o}, 0);
    endtask

    task automatic run_case(input int idx, input vec_t v);
        logic [DM-1:0]   coef [N];
        logic [N*DM-1:0] vec;
        logic [7:0]      held;
        logic            held_last;
        bit              holding, saw_err, saw_done, aborted;
        int              ci, bi, cyc, nb, need, acc_cyc, first_cyc;

        nb   = N * v.d / 8;
        need = (8 + v.d - 1) / v.d;
        vec  = '0;
        for (int k = 0; k < N; k++) begin
            case (v.pat)
                0:       coef[k] = 12'hFFF;
                1:       coef[k] = 12'(k);
                2:       coef[k] = (k == 0) ? 12'h123 : ((k == 1) ? 12'hABC : 12'h000);
                3:       coef[k] = 12'($urandom);
                default: coef[k] = 12'(k * 37);
            endcase
            coef[k] = coef[k] & 12'((1 << v.d) - 1);
            for (int b = 0; b < v.d; b++) vec[k * v.d + b] = coef[k][b];
        end

        @(negedge clk_i);
        start_i = 1'b1;
        d_i     = 4'(v.d);
        @(negedge clk_i);
        start_i = 1'b0;
        check($sformatf("c%0d_busy_after_start", idx), busy_o, 1);

        ci = 0; bi = 0; cyc = 0; acc_cyc = -1; first_cyc = -1;
        holding = 0; saw_err = 0; saw_done = 0; aborted = 0;
        held = 8'h00; held_last = 1'b0;
        while (bi < nb && cyc < 6000) begin
            if (err_o)  saw_err  = 1;
            if (done_o) saw_done = 1;
            if (holding)
                check($sformatf("c%0d_stall_hold_b%0d", idx, bi),
                      {byte_valid_o, byte_last_o, byte_o}, {1'b1, held_last, held});
            if (byte_valid_o && first_cyc < 0) first_cyc = cyc;

            coeff_valid_i = (ci < N) && ($urandom_range(0, 99) < v.valid_pct);
            coeff_i       = (ci < N) ? (coef[ci] | 12'($urandom << v.d)) : 12'($urandom);
            byte_ready_i  = ($urandom_range(0, 99) < v.ready_pct);
            start_i       = ($urandom_range(0, 3) == 0);
            d_i           = 4'($urandom_range(0, 15));

            if (coeff_valid_i && coeff_ready_o) begin
                ci++;
                if (ci == need) acc_cyc = cyc;
            end
            holding   = byte_valid_o && !byte_ready_i;
            held      = byte_o;
            held_last = byte_last_o;
            if (byte_valid_o && byte_ready_i) begin
                if (v.chk_head && bi < 3)
                    check($sformatf("c%0d_head_b%0d", idx, bi), byte_o, v.head[8*bi +: 8]);
                check($sformatf("c%0d_byte%0d", idx, bi), byte_o, vec[8*bi +: 8]);
                check($sformatf("c%0d_last%0d", idx, bi), byte_last_o, (bi == nb - 1) ? 1 : 0);
                bi++;
                if (v.abort_at != 0 && bi == v.abort_at) begin
                    rst_i   = 1'b1;
                    aborted = 1;
                    break;
                end
            end
            cyc++;
            @(negedge clk_i);
        end

        if (cyc >= 6000) begin
            check($sformatf("c%0d_timeout_bytes", idx), bi, nb);
            rst_i = 1'b1;
            @(negedge clk_i);
            rst_i = 1'b0;
        end

        check($sformatf("c%0d_first_byte_latency", idx), first_cyc, acc_cyc + 1);
        check($sformatf("c%0d_no_err_while_busy", idx), saw_err, 0);
        check($sformatf("c%0d_no_early_done", idx), saw_done, 0);

        if (aborted) begin
            @(negedge clk_i);
            rst_i = 1'b0;
            start_i = 1'b0; coeff_valid_i = 1'b0; byte_ready_i = 1'b0; d_i = 4'd0;
            check_idle($sformatf("c%0d_abort", idx));
        end else if (cyc < 6000) begin
            start_i = 1'b0; coeff_valid_i = 1'b0; byte_ready_i = 1'b0; d_i = 4'd0;
            check($sformatf("c%0d_coeffs_consumed", idx), ci, N);
            check($sformatf("c%0d_done_pulse", idx), done_o, 1);
            check($sformatf("c%0d_idle_at_done", idx), {busy_o, byte_valid_o, coeff_ready_o}, 0);
            @(negedge clk_i);
            check($sformatf("c%0d_done_one_cycle", idx), done_o, 0);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; d_i = 4'd0; coeff_i = '0;
        coeff_valid_i = 1'b0; byte_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check_idle("in_reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_idle("after_reset");

        tbl[0] = '{1,  0, 100, 100, 0,  1'b1, 24'hFFFFFF};
        tbl[1] = '{4,  1, 100, 100, 0,  1'b1, 24'h543210};
        tbl[2] = '{12, 2, 100, 100, 0,  1'b1, 24'hABC123};
        tbl[3] = '{12, 3, 30,  80,  0,  1'b0, 24'h000000};
        tbl[4] = '{10, 4, 100, 100, 50, 1'b1, 24'hA09400};
        tbl[5] = '{10, 4, 100, 100, 0,  1'b1, 24'hA09400};
        tbl[6] = '{3,  1, 60,  70,  0,  1'b1, 24'hFAC688};

        for (int i = 0; i < 7; i++) run_case(i, tbl[i]);

        bad_start(4'd13);
        bad_start(4'd0);
        bad_start(4'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
